ncl_pipe_adder: RTL and testbench

NCL_PIPE_ADDER -- requirements
Module: ncl_pipe_adder

---
 rtl/ncl_pipe_adder.sv | 107 ++++++++++
 tb/tb_ncl_pipe_adder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_pipe_adder.sv
// ncl_pipe_adder: clocked dual-rail NCL ripple adder, one four-phase pipeline stage per digit.
// Stage k resolves sum digit k and forwards the remaining operand digits to stage k+1.
module ncl_pipe_adder #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               init,
   input  logic [2*WIDTH-1:0] A,
   input  logic [2*WIDTH-1:0] B,
   input  logic [1:0]         carryin,
   input  logic               sumCOMP,
   output logic               inCOMP,
   output logic [2*WIDTH-1:0] sum,
   output logic [1:0]         carryout,
   output logic               err
);
   localparam int N = 2 * WIDTH;
   logic         p_q [WIDTH];
   logic         p_d [WIDTH];
   logic [N-1:0] a_q [WIDTH];
   logic [N-1:0] a_d [WIDTH];
   logic [N-1:0] b_q [WIDTH];
   logic [N-1:0] b_d [WIDTH];
   logic [N-1:0] s_q [WIDTH];
   logic [N-1:0] s_d [WIDTH];
   logic [1:0]   c_q [WIDTH];
   logic [1:0]   c_d [WIDTH];
   logic         err_q, err_d, in_data, in_null;
   // index k feeds stage k; dn_p[k+1] is the phase of stage k's successor
   logic [N-1:0] src_a [WIDTH+1];
   logic [N-1:0] src_b [WIDTH+1];
   logic [N-1:0] src_s [WIDTH+1];
   logic [1:0]   src_c [WIDTH+1];
   logic         src_p [WIDTH+1];
   logic         dn_p  [WIDTH+1];
   logic         cap, x, y, z, sv, cv;
   always_comb begin
      in_data = carryin[0] ^ carryin[1];
      in_null = ~|carryin;
      err_d   = err_q | (&carryin);
      for (int i = 0; i < WIDTH; i++) begin
         in_data = in_data & (A[2*i] ^ A[2*i+1]) & (B[2*i] ^ B[2*i+1]);
         in_null = in_null & ~|A[2*i+:2] & ~|B[2*i+:2];
         err_d   = err_d | (&A[2*i+:2]) | (&B[2*i+:2]);
      end
   end
   always_comb begin
      src_a[0] = A;
      src_b[0] = B;
      src_s[0] = '0;
      src_c[0] = carryin;
      src_p[0] = in_data;
      dn_p[WIDTH] = sumCOMP;
      cap = 1'b0;
      x = 1'b0;
      y = 1'b0;
      z = 1'b0;
      sv = 1'b0;
      cv = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         src_a[k+1] = a_q[k];
         src_b[k+1] = b_q[k];
         src_s[k+1] = s_q[k];
         src_c[k+1] = c_q[k];
         src_p[k+1] = p_q[k];
         dn_p[k]    = p_q[k];
      end
      for (int k = 0; k < WIDTH; k++) begin
         cap = (k != 0 || in_data || in_null) && (src_p[k] != p_q[k]) && (dn_p[k+1] == p_q[k]);
         x = src_a[k][2*k+1];
         y = src_b[k][2*k+1];
         z = src_c[k][1];
         sv = x ^ y ^ z;
         cv = (x & y) | (x & z) | (y & z);
         p_d[k] = p_q[k] ^ cap;
         a_d[k] = !cap ? a_q[k] : p_q[k] ? '0 : src_a[k];
         b_d[k] = !cap ? b_q[k] : p_q[k] ? '0 : src_b[k];
         s_d[k] = !cap ? s_q[k] : p_q[k] ? '0 : src_s[k] | (N'({sv, ~sv}) << (2 * k));
         c_d[k] = !cap ? c_q[k] : p_q[k] ? 2'b00 : {cv, ~cv};
      end
   end
   always_ff @(posedge clk) begin
      if (init) begin
         err_q <= 1'b0;
         for (int k = 0; k < WIDTH; k++) begin
            p_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 2'b00;
         end
      end else begin
         err_q <= err_d;
         for (int k = 0; k < WIDTH; k++) begin
            p_q[k] <= p_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
         end
      end
   end
   assign inCOMP   = p_q[0];
   assign sum      = s_q[WIDTH-1];
   assign carryout = c_q[WIDTH-1];
   assign err      = err_q;
endmodule

// File: tb/tb_ncl_pipe_adder.sv
// tb_ncl_pipe_adder: directed vectors and handshake sequences on a WIDTH=4 adder,
// plus randomized four-phase streams on WIDTH=1/4/8 checked against integer sums.
module tb_ncl_pipe_adder;
   localparam int RN = 16;
   typedef struct {
      int         a;
      int         b;
      int         c;
      logic [7:0] es;
      logic [1:0] ec;
   } vec_t;
   logic       clk = 1'b0;
   logic       init, scomp, icomp, err;
   logic [7:0] A, B, sum;
   logic [1:0] cin, cout;
   int         n_cmp = 0;
   int         n_bad = 0;
   vec_t       tv [7];

   always #5 clk = ~clk;

   ncl_pipe_adder #(.WIDTH(4)) dut (
      .clk(clk), .init(init), .A(A), .B(B), .carryin(cin), .sumCOMP(scomp),
      .inCOMP(icomp), .sum(sum), .carryout(cout), .err(err)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int v, input int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[2*i+:2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic logic [7:0] enc4(input int v);
      logic [15:0] r;
      r = enc(v, 4);
      return r[7:0];
   endfunction

   function automatic logic [1:0] encb(input int v);
      return v[0] ? 2'b10 : 2'b01;
   endfunction

   task automatic drive(input int a, input int b, input int c);
      A = enc4(a);
      B = enc4(b);
      cin = encb(c);
   endtask

   task automatic drive_null;
      A = '0;
      B = '0;
      cin = 2'b00;
   endtask

   // one full DATA/NULL handshake with exact latency checks from an idle pipeline
   task automatic wave(input vec_t v, input string nm);
      drive(v.a, v.b, v.c);
      scomp = 1'b0;
      tick(1);
      chk({nm, "_incomp_data"}, icomp, 1);
      tick(2);
      chk({nm, "_not_early"}, cout, 0);
      tick(1);
      chk({nm, "_sum"}, sum, v.es);
      chk({nm, "_cout"}, cout, v.ec);
      drive_null;
      scomp = 1'b1;
      tick(1);
      chk({nm, "_incomp_null"}, icomp, 0);
      tick(3);
      chk({nm, "_null_out"}, {sum, cout}, 0);
      scomp = 1'b0;
   endtask

   initial begin
      logic dn;
      tv[0] = '{5, 6, 0, 8'h9A, 2'b01};
      tv[1] = '{15, 1, 1, 8'h56, 2'b10};
      tv[2] = '{3, 4, 0, 8'h6A, 2'b01};
      tv[3] = '{0, 0, 0, 8'h55, 2'b01};
      tv[4] = '{15, 15, 1, 8'hAA, 2'b10};
      tv[5] = '{9, 7, 0, 8'h55, 2'b10};
      tv[6] = '{12, 2, 1, 8'hAA, 2'b01};
      init = 1'b1;
      scomp = 1'b0;
      drive_null;
      tick(2);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_incomp", icomp, 0);
      chk("rst_err", err, 0);
      init = 1'b0;
      for (int i = 0; i < 7; i++) wave(tv[i], $sformatf("vec%0d", i));
      fork
         begin : bp_prod
            logic pk;
            for (int i = 0; i < 3; i++) begin
               drive(tv[i].a, tv[i].b, tv[i].c);
               pk = 1'b0;
               for (int t = 0; t < 100 && !pk; t++) begin
                  tick(1);
                  pk = icomp;
               end
               chk($sformatf("bp_ack_data%0d", i), pk, 1);
               drive_null;
               pk = 1'b0;
               for (int t = 0; t < 100 && !pk; t++) begin
                  tick(1);
                  pk = !icomp;
               end
               chk($sformatf("bp_ack_null%0d", i), pk, 1);
            end
         end
         begin : bp_cons
            logic ck;
            ck = 1'b0;
            for (int t = 0; t < 20 && !ck; t++) begin
               tick(1);
               ck = cout != 2'b00;
            end
            chk("bp_first_out", ck, 1);
            tick(16);
            chk("bp_stall_sum_a", sum, 8'h9A);
            chk("bp_stall_incomp_a", icomp, 0);
            tick(4);
            chk("bp_stall_sum_b", sum, 8'h9A);
            chk("bp_stall_incomp_b", icomp, 0);
            for (int j = 0; j < 3; j++) begin
               ck = 1'b0;
               for (int t = 0; t < 60 && !ck; t++) begin
                  ck = cout != 2'b00;
                  if (!ck) tick(1);
               end
               chk($sformatf("bp_out_arrive%0d", j), ck, 1);
               chk($sformatf("bp_out_sum%0d", j), sum, tv[j].es);
               chk($sformatf("bp_out_cout%0d", j), cout, tv[j].ec);
               scomp = 1'b1;
               ck = 1'b0;
               for (int t = 0; t < 60 && !ck; t++) begin
                  tick(1);
                  ck = cout == 2'b00;
               end
               chk($sformatf("bp_out_null%0d", j), ck, 1);
               scomp = 1'b0;
            end
         end
      join
      tick(6);
      chk("bp_drained_out", {sum, cout}, 0);
      chk("bp_drained_incomp", icomp, 0);
      drive(5, 6, 0);
      A[5:4] = 2'b11;
      chk("err_pre", err, 0);
      tick(1);
      chk("err_set", err, 1);
      chk("err_block_a", icomp, 0);
      tick(2);
      chk("err_block_b", icomp, 0);
      drive_null;
      tick(3);
      chk("err_sticky", err, 1);
      init = 1'b1;
      tick(1);
      init = 1'b0;
      chk("err_cleared", err, 0);
      cin = 2'b11;
      tick(1);
      chk("err_carryin", err, 1);
      cin = 2'b00;
      init = 1'b1;
      tick(1);
      init = 1'b0;
      drive(5, 6, 0);
      tick(1);
      drive_null;
      tick(2);
      drive(15, 1, 1);
      tick(2);
      chk("inflight_out", sum, 8'h9A);
      chk("inflight_incomp", icomp, 1);
      init = 1'b1;
      tick(1);
      chk("init_flush_out", {sum, cout}, 0);
      chk("init_flush_incomp", icomp, 0);
      chk("init_flush_err", err, 0);
      init = 1'b0;
      wave(tv[2], "post_init");
      dn = 1'b0;
      for (int t = 0; t < 20000 && !dn; t++) begin
         tick(1);
         dn = rs[0].fin & rs[1].fin & rs[2].fin;
      end
      chk("rand_streams_done", dn, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   for (genvar g = 0; g < 3; g++) begin : rs
      localparam int RW = (g == 0) ? 1 : (g == 1) ? 4 : 8;
      logic            ri, rsc, ric, rerr;
      logic            fin = 1'b0;
      logic [2*RW-1:0] ra, rb, rsum;
      logic [1:0]      rc, rcout;
      int              va [RN];
      int              vb [RN];
      int              vc [RN];

      ncl_pipe_adder #(.WIDTH(RW)) u (
         .clk(clk), .init(ri), .A(ra), .B(rb), .carryin(rc), .sumCOMP(rsc),
         .inCOMP(ric), .sum(rsum), .carryout(rcout), .err(rerr)
      );

      initial begin
         logic [15:0] e;
         ri = 1'b1;
         rsc = 1'b0;
         ra = '0;
         rb = '0;
         rc = 2'b00;
         for (int i = 0; i < RN; i++) begin
            va[i] = int'($urandom_range(0, (1 << RW) - 1));
            vb[i] = int'($urandom_range(0, (1 << RW) - 1));
            vc[i] = int'($urandom_range(0, 1));
         end
         tick(2);
         ri = 1'b0;
         e = enc(1, RW);
         ra = e[2*RW-1:0];
         rb = e[2*RW-1:0];
         rc = 2'b10;
         tick(RW);
         e = enc(3, RW);
         chk($sformatf("w%0d_111_sum", RW), rsum, e[2*RW-1:0]);
         chk($sformatf("w%0d_111_cout", RW), rcout, encb((3 >> RW) & 1));
         ra = '0;
         rb = '0;
         rc = 2'b00;
         rsc = 1'b1;
         tick(RW);
         chk($sformatf("w%0d_111_null", RW), {rsum, rcout}, 0);
         rsc = 1'b0;
         fork
            begin : prod
               logic [15:0] pe;
               logic        pk;
               for (int i = 0; i < RN; i++) begin
                  tick(int'($urandom_range(0, 2)));
                  pe = enc(va[i], RW);
                  ra = pe[2*RW-1:0];
                  pe = enc(vb[i], RW);
                  rb = pe[2*RW-1:0];
                  rc = encb(vc[i]);
                  pk = 1'b0;
                  for (int t = 0; t < 300 && !pk; t++) begin
                     tick(1);
                     pk = ric;
                  end
                  chk($sformatf("w%0d_prod_data%0d", RW, i), pk, 1);
                  ra = '0;
                  rb = '0;
                  rc = 2'b00;
                  pk = 1'b0;
                  for (int t = 0; t < 300 && !pk; t++) begin
                     tick(1);
                     pk = !ric;
                  end
                  chk($sformatf("w%0d_prod_null%0d", RW, i), pk, 1);
               end
            end
            begin : cons
               logic [15:0] ce;
               logic        ck;
               int          tot;
               for (int j = 0; j < RN; j++) begin
                  ck = 1'b0;
                  for (int t = 0; t < 300 && !ck; t++) begin
                     tick(1);
                     ck = rcout != 2'b00;
                  end
                  chk($sformatf("w%0d_arrive%0d", RW, j), ck, 1);
                  tot = va[j] + vb[j] + vc[j];
                  ce = enc(tot, RW);
                  chk($sformatf("w%0d_sum%0d", RW, j), rsum, ce[2*RW-1:0]);
                  chk($sformatf("w%0d_cout%0d", RW, j), rcout, encb((tot >> RW) & 1));
                  tick(int'($urandom_range(0, 3)));
                  rsc = 1'b1;
                  ck = 1'b0;
                  for (int t = 0; t < 300 && !ck; t++) begin
                     tick(1);
                     ck = rcout == 2'b00;
                  end
                  chk($sformatf("w%0d_null%0d", RW, j), ck, 1);
                  tick(int'($urandom_range(0, 3)));
                  rsc = 1'b0;
               end
            end
         join
         chk($sformatf("w%0d_no_err", RW), rerr, 0);
         fin = 1'b1;
      end
   end
endmodule
